// File: rtl/cardinal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cardinal_pkg
// Description : Shared constants and types for the Cardinal ring router:
//               packet geometry, VC tag position, hop field bounds, VC phase
//               names, slot occupancy flags and arbiter priority encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package cardinal_pkg;

    // Packet geometry
    localparam int PACKET_WIDTH = 64;
    localparam int HOP_WIDTH    = 8;

    // Bit 0 of every packet carries its virtual channel
    localparam int VC_BIT       = 0;

    // Hop count lives in bits [15:8]
    localparam int HOP_LSB      = 8;
    localparam int HOP_MSB      = HOP_LSB + HOP_WIDTH - 1;

    // Virtual channel / polarity phases
    localparam logic EVEN       = 1'b0;
    localparam logic ODD        = 1'b1;

    // Slot occupancy
    localparam logic FULL       = 1'b1;
    localparam logic EMPTY      = 1'b0;

    // Round-robin priority encoding: which input wins a contended output
    localparam logic PRIO_RING  = 1'b0;
    localparam logic PRIO_PE    = 1'b1;

    typedef logic [PACKET_WIDTH-1:0] packet_t;

endpackage
`default_nettype wire

// File: rtl/cardinal_vc_slot.sv
`default_nettype none
// ============================================================================
// Module      : cardinal_vc_slot
// Description : One-entry packet buffer with a full flag. A write loads the
//               packet and marks the slot full; a clear marks it empty.
// Revision    : 1.0 - initial release
// ============================================================================
module cardinal_vc_slot #(
    parameter int WIDTH = cardinal_pkg::PACKET_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr,
    output logic             full,
    output logic [WIDTH-1:0] data
);
    import cardinal_pkg::*;

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Load on write, drop on clear; the router never asserts both together
    // because a write needs an empty slot and a clear needs a full one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= EMPTY;
            r_data <= '0;
        end else if (wr_en) begin
            r_full <= FULL;
            r_data <= wr_data;
        end else if (clr) begin
            r_full <= EMPTY;
        end
    end

    assign full = r_full;
    assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/cardinal_ring_router.sv
`default_nettype none
// ============================================================================
// Module      : cardinal_ring_router
// Description : Unidirectional ring router node with two time-multiplexed
//               virtual channels. Each cycle of polarity p captures incoming
//               packets of VC !p, switches VC p input slots to output slots
//               and launches VC p output slots onto the links.
//               Optional feature macro: CARDINAL_LOOPBACK_EN - when defined,
//               PE packets with hop 0 are delivered back to the local PE and
//               pe_out is arbitrated between ring-in and pe-in.
// Revision    : 1.0 - initial release
// ============================================================================
module cardinal_ring_router #(
    parameter int PACKET_WIDTH = cardinal_pkg::PACKET_WIDTH,
    parameter int HOP_WIDTH    = cardinal_pkg::HOP_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    polarity,
    input  logic                    pesi,
    input  logic [PACKET_WIDTH-1:0] pedi,
    output logic                    peri,
    output logic                    peso,
    output logic [PACKET_WIDTH-1:0] pedo,
    input  logic                    pero,
    input  logic                    rsi,
    input  logic [PACKET_WIDTH-1:0] rdi,
    output logic                    rri,
    output logic                    rso,
    output logic [PACKET_WIDTH-1:0] rdo,
    input  logic                    rro
);
    import cardinal_pkg::*;

    localparam int                   HOP_LO   = HOP_LSB;
    localparam int                   HOP_HI   = HOP_LSB + HOP_WIDTH - 1;
    localparam logic [HOP_WIDTH-1:0] HOP_ZERO = '0;
    localparam logic [HOP_WIDTH-1:0] HOP_ONE  = HOP_WIDTH'(1);

    typedef logic [PACKET_WIDTH-1:0] pkt_t;

    // Ring forwarding: decrement a nonzero hop, pass a zero hop untouched
    function automatic pkt_t hop_forward(input pkt_t pkt);
        pkt_t res;
        res = pkt;
        if (pkt[HOP_HI:HOP_LO] != HOP_ZERO) begin
            res[HOP_HI:HOP_LO] = pkt[HOP_HI:HOP_LO] - HOP_ONE;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Global phase
    // ------------------------------------------------------------------
    logic r_polarity;

    // Phase toggles every cycle; shared reset keeps all nodes aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            r_polarity <= EVEN;
        end else begin
            r_polarity <= ~r_polarity;
        end
    end

    // ------------------------------------------------------------------
    // Slot storage, indexed by VC
    // ------------------------------------------------------------------
    logic [1:0] w_ri_full, w_pi_full, w_ro_full, w_po_full;
    pkt_t       w_ri_data [2];
    pkt_t       w_pi_data [2];
    pkt_t       w_ro_data [2];
    pkt_t       w_po_data [2];
    logic [1:0] w_ri_wr, w_pi_wr, w_ro_wr, w_po_wr;
    logic [1:0] w_ri_clr, w_pi_clr, w_ro_clr, w_po_clr;
    pkt_t       w_ro_wdata;
    pkt_t       w_po_wdata;

    generate
        for (genvar v = 0; v < 2; v++) begin : g_vc
            cardinal_vc_slot #(.WIDTH(PACKET_WIDTH)) u_ring_in (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (w_ri_wr[v]),
                .wr_data (rdi),
                .clr     (w_ri_clr[v]),
                .full    (w_ri_full[v]),
                .data    (w_ri_data[v])
            );
            cardinal_vc_slot #(.WIDTH(PACKET_WIDTH)) u_pe_in (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (w_pi_wr[v]),
                .wr_data (pedi),
                .clr     (w_pi_clr[v]),
                .full    (w_pi_full[v]),
                .data    (w_pi_data[v])
            );
            cardinal_vc_slot #(.WIDTH(PACKET_WIDTH)) u_ring_out (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (w_ro_wr[v]),
                .wr_data (w_ro_wdata),
                .clr     (w_ro_clr[v]),
                .full    (w_ro_full[v]),
                .data    (w_ro_data[v])
            );
            cardinal_vc_slot #(.WIDTH(PACKET_WIDTH)) u_pe_out (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (w_po_wr[v]),
                .wr_data (w_po_wdata),
                .clr     (w_po_clr[v]),
                .full    (w_po_full[v]),
                .data    (w_po_data[v])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Route requests for the active VC (the one matching polarity)
    // ------------------------------------------------------------------
    logic w_ri_hop_zero;
    logic w_rin_req_ro, w_rin_req_po;
    logic w_pin_req_ro;

    assign w_ri_hop_zero = (w_ri_data[r_polarity][HOP_HI:HOP_LO] == HOP_ZERO);
    assign w_rin_req_ro  = w_ri_full[r_polarity] & ~w_ri_hop_zero;
    assign w_rin_req_po  = w_ri_full[r_polarity] &  w_ri_hop_zero;

`ifdef CARDINAL_LOOPBACK_EN
    logic w_pi_hop_zero;
    logic w_pin_req_po;

    assign w_pi_hop_zero = (w_pi_data[r_polarity][HOP_HI:HOP_LO] == HOP_ZERO);
    assign w_pin_req_ro  = w_pi_full[r_polarity] & ~w_pi_hop_zero;
    assign w_pin_req_po  = w_pi_full[r_polarity] &  w_pi_hop_zero;
`else
    // Without loopback a hop-0 PE packet still leaves on the ring and is
    // delivered by the next downstream node.
    assign w_pin_req_ro  = w_pi_full[r_polarity];
`endif

    // ------------------------------------------------------------------
    // ring_out arbitration (both inputs can target it)
    // ------------------------------------------------------------------
    logic [1:0] r_prio_ro;
    logic       w_ro_free;
    logic       w_ro_contend;
    logic       w_ro_gnt_ring, w_ro_gnt_pe;

    assign w_ro_free     = (w_ro_full[r_polarity] == EMPTY);
    assign w_ro_contend  = w_ro_free & w_rin_req_ro & w_pin_req_ro;
    assign w_ro_gnt_ring = w_ro_free & w_rin_req_ro &
                           (~w_pin_req_ro | (r_prio_ro[r_polarity] == PRIO_RING));
    assign w_ro_gnt_pe   = w_ro_free & w_pin_req_ro &
                           (~w_rin_req_ro | (r_prio_ro[r_polarity] == PRIO_PE));
    assign w_ro_wdata    = w_ro_gnt_ring ? hop_forward(w_ri_data[r_polarity])
                                         : hop_forward(w_pi_data[r_polarity]);

    // Hand priority to the loser only when a contended move actually happens
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio_ro <= {2{PRIO_RING}};
        end else if (w_ro_contend) begin
            r_prio_ro[r_polarity] <= ~r_prio_ro[r_polarity];
        end
    end

    // ------------------------------------------------------------------
    // pe_out arbitration
    // ------------------------------------------------------------------
    logic w_po_free;
    logic w_po_gnt_ring, w_po_gnt_pe;

    assign w_po_free = (w_po_full[r_polarity] == EMPTY);

`ifdef CARDINAL_LOOPBACK_EN
    logic [1:0] r_prio_po;
    logic       w_po_contend;

    assign w_po_contend  = w_po_free & w_rin_req_po & w_pin_req_po;
    assign w_po_gnt_ring = w_po_free & w_rin_req_po &
                           (~w_pin_req_po | (r_prio_po[r_polarity] == PRIO_RING));
    assign w_po_gnt_pe   = w_po_free & w_pin_req_po &
                           (~w_rin_req_po | (r_prio_po[r_polarity] == PRIO_PE));
    assign w_po_wdata    = w_po_gnt_ring ? w_ri_data[r_polarity]
                                         : w_pi_data[r_polarity];

    // Round-robin update for the local delivery port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio_po <= {2{PRIO_RING}};
        end else if (w_po_contend) begin
            r_prio_po[r_polarity] <= ~r_prio_po[r_polarity];
        end
    end
`else
    // Ring-in is the only source of pe_out, so no arbiter is needed
    assign w_po_gnt_ring = w_po_free & w_rin_req_po;
    assign w_po_gnt_pe   = 1'b0;
    assign w_po_wdata    = w_ri_data[r_polarity];
`endif

    // ------------------------------------------------------------------
    // Slot write/clear strobes
    // ------------------------------------------------------------------
    // Capture targets VC !p (sender's choice), switch and send touch VC p only
    always_comb begin
        w_ri_wr  = '0;
        w_pi_wr  = '0;
        w_ro_wr  = '0;
        w_po_wr  = '0;
        w_ri_clr = '0;
        w_pi_clr = '0;
        w_ro_clr = '0;
        w_po_clr = '0;

        w_ri_wr[rdi[VC_BIT]]  = rsi;
        w_pi_wr[pedi[VC_BIT]] = pesi;

        w_ro_wr[r_polarity]   = w_ro_gnt_ring | w_ro_gnt_pe;
        w_po_wr[r_polarity]   = w_po_gnt_ring | w_po_gnt_pe;
        w_ri_clr[r_polarity]  = w_ro_gnt_ring | w_po_gnt_ring;
        w_pi_clr[r_polarity]  = w_ro_gnt_pe   | w_po_gnt_pe;

        w_ro_clr[r_polarity]  = w_ro_full[r_polarity] & rro;
        w_po_clr[r_polarity]  = w_po_full[r_polarity] & pero;
    end

    // ------------------------------------------------------------------
    // Link outputs
    // ------------------------------------------------------------------
    logic                    r_rso, r_peso;
    logic [PACKET_WIDTH-1:0] r_rdo, r_pedo;

    // Register the launch; data holds its last value between pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rso  <= 1'b0;
            r_rdo  <= '0;
            r_peso <= 1'b0;
            r_pedo <= '0;
        end else begin
            r_rso  <= w_ro_clr[r_polarity];
            r_peso <= w_po_clr[r_polarity];
            if (w_ro_clr[r_polarity]) begin
                r_rdo <= w_ro_data[r_polarity];
            end
            if (w_po_clr[r_polarity]) begin
                r_pedo <= w_po_data[r_polarity];
            end
        end
    end

    assign polarity = r_polarity;
    assign rri      = (w_ri_full[r_polarity] == EMPTY);
    assign peri     = (w_pi_full[r_polarity] == EMPTY);
    assign rso      = r_rso;
    assign rdo      = r_rdo;
    assign peso     = r_peso;
    assign pedo     = r_pedo;

endmodule
`default_nettype wire

// File: tb/tb_cardinal_ring_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_cardinal_ring_router
// Description : Scoreboard bench for cardinal_ring_router. Stimulus pushes
//               hand-computed expected packets per output link; a monitor
//               pops and compares on every rso/peso pulse.
//               Honours CARDINAL_LOOPBACK_EN for the hop-0 PE packet case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cardinal_ring_router;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        pesi, peri, peso, pero;
    logic [63:0] pedi, pedo;
    logic        rsi, rri, rso, rro;
    logic [63:0] rdi, rdo;

    cardinal_ring_router dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .pesi     (pesi),
        .pedi     (pedi),
        .peri     (peri),
        .peso     (peso),
        .pedo     (pedo),
        .pero     (pero),
        .rsi      (rsi),
        .rdi      (rdi),
        .rri      (rri),
        .rso      (rso),
        .rdo      (rdo),
        .rro      (rro)
    );

    always #5 clk = ~clk;

    int   cyc     = 0;
    logic exp_pol = 1'b0;
    int   total   = 0;
    int   passed  = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) exp_pol <= reset ? 1'b0 : ~exp_pol;

    typedef struct {
        logic [63:0] data;
        int          at;
    } exp_t;

    exp_t rq[$];
    exp_t pq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    endtask

    function automatic void exp_ring(input logic [63:0] d, input int at);
        rq.push_back('{d, at});
    endfunction

    function automatic void exp_pe(input logic [63:0] d, input int at);
        pq.push_back('{d, at});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a cycle whose phase matches the packet VC with the needed
    // readies high, then present the packet(s) in the following cycle.
    task automatic send(input bit use_r, input logic [63:0] rp,
                        input bit use_p, input logic [63:0] pp, output int sc);
        logic vc;
        int   n;
        vc = use_r ? rp[0] : pp[0];
        n  = 0;
        sc = -1;
        while (!((exp_pol == vc) && (!use_r || rri === 1'b1) && (!use_p || peri === 1'b1))) begin
            if (n == 100) begin
                total++;
                $display("FAIL send_ready_timeout: ready still low after %0d cycles, expected 1", n);
                return;
            end
            tick();
            n++;
        end
        tick();
        rsi  = use_r;
        rdi  = rp;
        pesi = use_p;
        pedi = pp;
        sc   = cyc;
        tick();
        rsi  = 1'b0;
        pesi = 1'b0;
    endtask

    // Monitor: phase every cycle, and every link pulse against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (cyc >= 1) begin
            check("polarity", polarity, exp_pol);
            if (rso !== 1'b0) begin
                if (rq.size() == 0) begin
                    total++;
                    $display("FAIL rso_unexpected: got rso=%b rdo=%h, expected no pulse (cycle %0d)", rso, rdo, cyc);
                end else begin
                    e = rq.pop_front();
                    check("rdo", rdo, e.data);
                    if (e.at >= 0) check("rso_cycle", cyc, e.at);
                end
            end
            if (peso !== 1'b0) begin
                if (pq.size() == 0) begin
                    total++;
                    $display("FAIL peso_unexpected: got peso=%b pedo=%h, expected no pulse (cycle %0d)", peso, pedo, cyc);
                end else begin
                    e = pq.pop_front();
                    check("pedo", pedo, e.data);
                    if (e.at >= 0) check("peso_cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int sc;
        reset = 1'b1;
        rsi   = 1'b0;
        rdi   = '0;
        pesi  = 1'b0;
        pedi  = '0;
        rro   = 1'b1;
        pero  = 1'b1;

        // Reset state
        tick();
        tick();
        check("reset_rri",  rri,  1);
        check("reset_peri", peri, 1);
        check("reset_rso",  rso,  0);
        check("reset_peso", peso, 0);
        check("reset_rdo",  rdo,  0);
        check("reset_pedo", pedo, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("polarity_seq", polarity, i % 2);
            tick();
        end

        // Injection: VC0 hop 3 from PE goes out on the ring with hop 2
        send(0, '0, 1, 64'h1234_5678_9ABC_0300, sc);
        if (sc >= 0) exp_ring(64'h1234_5678_9ABC_0200, sc + 4);
        repeat (8) tick();
        check("rso_idle",  rso, 0);
        check("rdo_hold",  rdo, 64'h1234_5678_9ABC_0200);

        // Ejection: VC1 hop 0 from the ring is delivered to the PE
        send(1, 64'hCAFE_F00D_0000_0001, 0, '0, sc);
        if (sc >= 0) exp_pe(64'hCAFE_F00D_0000_0001, sc + 4);
        repeat (8) tick();

        // Contention with reset priority: ring wins, PE follows
        send(1, 64'hAAAA_0000_0000_0500, 1, 64'hBBBB_0000_0000_0200, sc);
        if (sc >= 0) begin
            exp_ring(64'hAAAA_0000_0000_0400, sc + 4);
            exp_ring(64'hBBBB_0000_0000_0100, -1);
        end
        repeat (12) tick();

        // Second contention: priority was handed to PE, which now wins
        send(1, 64'hCCCC_0000_0000_0300, 1, 64'hDDDD_0000_0000_0100, sc);
        if (sc >= 0) begin
            exp_ring(64'hDDDD_0000_0000_0000, sc + 4);
            exp_ring(64'hCCCC_0000_0000_0200, -1);
        end
        repeat (12) tick();

        // Backpressure: ring_out[0] then pe_in[0] fill while rro is low
        rro = 1'b0;
        send(0, '0, 1, 64'h1111_0000_0000_0700, sc);
        if (sc >= 0) exp_ring(64'h1111_0000_0000_0600, -1);
        send(0, '0, 1, 64'h2222_0000_0000_0600, sc);
        if (sc >= 0) exp_ring(64'h2222_0000_0000_0500, -1);
        for (int i = 0; i < 4; i++) begin
            check("bp_peri", peri, exp_pol);
            check("bp_rri",  rri,  1);
            tick();
        end
        rro = 1'b1;
        send(0, '0, 1, 64'h3333_0000_0000_0500, sc);
        if (sc >= 0) exp_ring(64'h3333_0000_0000_0400, -1);
        repeat (16) tick();

        // Hop-0 PE packet: local delivery with loopback, else ring with hop 0
        send(0, '0, 1, 64'h4444_0000_0000_0000, sc);
`ifdef CARDINAL_LOOPBACK_EN
        if (sc >= 0) exp_pe(64'h4444_0000_0000_0000, sc + 4);
`else
        if (sc >= 0) exp_ring(64'h4444_0000_0000_0000, sc + 4);
`endif
        repeat (10) tick();

        // Reset drops held packets and ignores a same-cycle si
        rro  = 1'b0;
        pero = 1'b0;
        send(0, '0, 1, 64'h5555_0000_0000_0400, sc);
        send(1, 64'h6666_0000_0000_0001, 0, '0, sc);
        repeat (4) tick();
        reset = 1'b1;
        rsi   = 1'b1;
        rdi   = 64'h7777_0000_0000_0001;
        tick();
        rsi   = 1'b0;
        tick();
        reset = 1'b0;
        rro   = 1'b1;
        pero  = 1'b1;
        check("post_reset_rri",  rri,  1);
        check("post_reset_peri", peri, 1);
        tick();
        check("post_reset_rri_vc1",  rri,  1);
        check("post_reset_peri_vc1", peri, 1);
        repeat (12) tick();

        while (rq.size() > 0) begin
            exp_t e;
            e = rq.pop_front();
            total++;
            $display("FAIL rso_missing: got no pulse, expected rdo=%h", e.data);
        end
        while (pq.size() > 0) begin
            exp_t e;
            e = pq.pop_front();
            total++;
            $display("FAIL peso_missing: got no pulse, expected pedo=%h", e.data);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
